// File: rtl/io1out_pad_pkg.sv
// Shared definitions for the single-bit output pad: FSM state encoding and
// the legal range of the hi-Z turnaround length.
package io1out_pad_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } pad_state_e;

    localparam int TURN_CYCLES_MIN = 1;
    localparam int TURN_CYCLES_MAX = 15;

    // Pins an out-of-range turnaround parameter back into the legal window.
    function automatic int clamp_turn_cycles(input int n);
        if (n < TURN_CYCLES_MIN) begin
            return TURN_CYCLES_MIN;
        end else if (n > TURN_CYCLES_MAX) begin
            return TURN_CYCLES_MAX;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/io1out_turn_ctr.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module io1out_turn_ctr
#(
    parameter int WIDTH = 2
)
(
    input  logic             clk,
    input  logic             real_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge clk or posedge real_rst) begin
        if (real_rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/io1out_pad.sv
// Single-bit tristate output pad selecting one of four sources, with a
// TURN_CYCLES hi-Z gap whenever the driving source changes or the pad releases.
// Build option: define PAD_OUT_REG_EN to register the data bit (1-cycle latency).
module io1out_pad
    import io1out_pad_pkg::*;
#(
    parameter int TURN_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       real_rst,
    input  logic       pin_0,
    input  logic       pin_1,
    input  logic       pin_2,
    input  logic       pin_3,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_sel,
    input  logic       cfg_en,
    output logic       cfg_ready,
    inout  wire        top_pin,
    output logic       top_oe
);

    localparam int TURN_EFF = clamp_turn_cycles(TURN_CYCLES);
    localparam int CTR_W    = $clog2(TURN_EFF + 1);
    localparam logic [CTR_W-1:0] TURN_LOAD = CTR_W'(TURN_EFF - 1);

    pad_state_e state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic [1:0] pend_sel_r, pend_sel_s;
    logic       pend_en_r, pend_en_s;
    logic       oe_r;
    logic       ready_r;
    logic       ctr_load_s;
    logic       ctr_dec_s;
    logic       ctr_zero_s;
    logic       accept_s;
    logic [3:0] pins_s;
    logic       data_s;

    assign pins_s   = {pin_3, pin_2, pin_1, pin_0};
    assign accept_s = cfg_valid & ready_r;

    io1out_turn_ctr #(
        .WIDTH (CTR_W)
    ) u_turn_ctr (
        .clk      (clk),
        .real_rst (real_rst),
        .load     (ctr_load_s),
        .load_val (TURN_LOAD),
        .dec      (ctr_dec_s),
        .zero     (ctr_zero_s)
    );

    // Next-state, selection and pending-config logic.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        pend_sel_s = pend_sel_r;
        pend_en_s  = pend_en_r;
        ctr_load_s = 1'b0;
        ctr_dec_s  = 1'b0;
        case (state_r)
            OFF: begin
                if (accept_s && cfg_en) begin
                    state_s = DRIVE;
                    sel_s   = cfg_sel;
                end else begin
                    state_s = OFF;
                end
            end
            DRIVE: begin
                // Re-selecting the current source keeps driving without a gap.
                if (accept_s && !(cfg_en && (cfg_sel == sel_r))) begin
                    state_s    = TURN;
                    pend_sel_s = cfg_sel;
                    pend_en_s  = cfg_en;
                    ctr_load_s = 1'b1;
                end else begin
                    state_s = DRIVE;
                end
            end
            TURN: begin
                if (ctr_zero_s) begin
                    sel_s   = pend_sel_r;
                    state_s = pend_en_r ? DRIVE : OFF;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end
            default: begin
                state_s = OFF;
            end
        endcase
    end

    // State registers; oe and ready are registered decodes of the next state.
    always_ff @(posedge clk or posedge real_rst) begin
        if (real_rst) begin
            state_r    <= OFF;
            sel_r      <= 2'd0;
            pend_sel_r <= 2'd0;
            pend_en_r  <= 1'b0;
            oe_r       <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            pend_sel_r <= pend_sel_s;
            pend_en_r  <= pend_en_s;
            oe_r       <= (state_s == DRIVE);
            ready_r    <= (state_s != TURN);
        end
    end

`ifdef PAD_OUT_REG_EN
    logic data_r;

    // Registered data bit, sampled with the selection that takes effect this edge.
    always_ff @(posedge clk or posedge real_rst) begin
        if (real_rst) begin
            data_r <= 1'b0;
        end else begin
            data_r <= pins_s[sel_s];
        end
    end

    assign data_s = data_r;
`else
    assign data_s = pins_s[sel_r];
`endif

    assign top_oe    = oe_r;
    assign cfg_ready = ready_r;
    assign top_pin   = oe_r ? data_s : 1'bz;

endmodule

// File: tb/tb_io1out_pad.sv
// Directed table-driven bench for io1out_pad (TURN_CYCLES=2) plus hand-written
// sequences for ignored config during TURN and asynchronous reset.
module tb_io1out_pad;

    logic       clk;
    logic       real_rst;
    logic       pin_0, pin_1, pin_2, pin_3;
    logic       cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_en;
    logic       cfg_ready;
    logic       top_oe;
    wire        top_pin;

    // A released pad reads 1 through the pull-up; drive data is chosen to be 0 then.
    pullup (top_pin);

    io1out_pad #(
        .TURN_CYCLES (2)
    ) dut (
        .clk       (clk),
        .real_rst  (real_rst),
        .pin_0     (pin_0),
        .pin_1     (pin_1),
        .pin_2     (pin_2),
        .pin_3     (pin_3),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_en    (cfg_en),
        .cfg_ready (cfg_ready),
        .top_pin   (top_pin),
        .top_oe    (top_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PAD_OUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    localparam logic [1:0] REL = 2'd2;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [1:0] sel;
        logic       en;
        logic [3:0] pins;
        logic       exp_oe;
        logic       exp_ready;
        logic [1:0] exp_pin;
    } vec_t;

    vec_t vecs [0:25];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(input logic rst, input logic v, input logic [1:0] sel,
                                input logic en, input logic [3:0] pins, input logic eo,
                                input logic er, input logic [1:0] ep);
        vec_t r;
        r.rst = rst; r.v = v; r.sel = sel; r.en = en; r.pins = pins;
        r.exp_oe = eo; r.exp_ready = er; r.exp_pin = ep;
        return r;
    endfunction

    task automatic apply(input logic v, input logic [1:0] sel, input logic en, input logic [3:0] pins);
        cfg_valid = v;
        cfg_sel   = sel;
        cfg_en    = en;
        {pin_3, pin_2, pin_1, pin_0} = pins;
    endtask

    task automatic check(input string name, input logic eo, input logic er,
                         input logic [1:0] ep, input logic pin_chk);
        logic exp_pad;
        exp_pad = (ep == REL) ? 1'b1 : ep[0];
        n_vec++;
        if ((top_oe !== eo) || (cfg_ready !== er) || (pin_chk && (top_pin !== exp_pad))) begin
            n_err++;
            $display("FAIL %s: got oe=%b ready=%b pin=%b, expected oe=%b ready=%b pin=%b",
                     name, top_oe, cfg_ready, top_pin, eo, er, exp_pad);
        end
    endtask

    task automatic cycle_check(input string name, input logic v, input logic [1:0] sel,
                               input logic en, input logic [3:0] pins, input logic eo,
                               input logic er, input logic [1:0] ep);
        @(posedge clk); #1;
        apply(v, sel, en, pins);
        @(negedge clk);
        check(name, eo, er, ep, 1'b1);
    endtask

    initial begin
        logic [3:0] prev_pins;
        logic       chk;
        n_vec = 0;
        n_err = 0;
        real_rst = 1'b1;
        apply(1'b0, 2'd0, 1'b0, 4'b0000);
        prev_pins = 4'b0000;

        //            rst   v     sel   en    pins     oe    rdy   pin
        vecs[0]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, REL);
        vecs[1]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, REL);
        vecs[2]  = mk(1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1, REL);
        vecs[3]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd1);
        vecs[4]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);
        vecs[5]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd1);
        vecs[6]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd1);
        vecs[7]  = mk(1'b0, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd1);
        vecs[8]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0, REL);
        vecs[9]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0, REL);
        vecs[10] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd1);
        vecs[11] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);
        vecs[12] = mk(1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd0);
        vecs[13] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b0, 1'b0, REL);
        vecs[14] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b0, 1'b0, REL);
        vecs[15] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        vecs[16] = mk(1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1);
        vecs[17] = mk(1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1);
        vecs[18] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);
        vecs[19] = mk(1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);
        vecs[20] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, REL);
        vecs[21] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, REL);
        vecs[22] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, REL);
        vecs[23] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0111, 1'b0, 1'b1, REL);
        vecs[24] = mk(1'b0, 1'b1, 2'd3, 1'b0, 4'b0111, 1'b0, 1'b1, REL);
        vecs[25] = mk(1'b0, 1'b0, 2'd0, 1'b0, 4'b0111, 1'b0, 1'b1, REL);

        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            real_rst = vecs[i].rst;
            apply(vecs[i].v, vecs[i].sel, vecs[i].en, vecs[i].pins);
            @(negedge clk);
            // Registered data lags a pin change by one cycle; only compare settled data.
            chk = (vecs[i].exp_pin == REL) || !REG_BUILD || (vecs[i].pins == prev_pins);
            check($sformatf("vec%0d", i), vecs[i].exp_oe, vecs[i].exp_ready, vecs[i].exp_pin, chk);
            prev_pins = vecs[i].pins;
        end

        // Config pulsed during TURN must be dropped; pending sel=1/en=1 still applies.
        cycle_check("turn_setup",   1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1, REL);
        cycle_check("turn_req",     1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd0);
        cycle_check("turn_ignore0", 1'b1, 2'd2, 1'b0, 4'b0010, 1'b0, 1'b0, REL);
        cycle_check("turn_ignore1", 1'b0, 2'd0, 1'b0, 4'b0010, 1'b0, 1'b0, REL);
        cycle_check("turn_pending", 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        cycle_check("data_latency", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1,
                    REG_BUILD ? 2'd1 : 2'd0);
        cycle_check("data_settled", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);

        // Reset mid-DRIVE releases the pad without waiting for a clock edge.
        #1 real_rst = 1'b1;
        #1 check("rst_drive_async", 1'b0, 1'b1, REL, 1'b1);
        @(posedge clk); #1 real_rst = 1'b0;
        @(negedge clk);
        check("rst_drive_off", 1'b0, 1'b1, REL, 1'b1);

        // Reset mid-TURN discards pending sel=0/en=1, so the pad stays OFF.
        cycle_check("rst_turn_off",   1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1, REL);
        cycle_check("rst_turn_drive", 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
        cycle_check("rst_turn_in",    1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, REL);
        #1 real_rst = 1'b1;
        #1 check("rst_turn_async", 1'b0, 1'b1, REL, 1'b1);
        @(posedge clk); #1 real_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_turn_stay%0d", k), 1'b0, 1'b1, REL, 1'b1);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
